// File: rtl/cacheline_arbiter_adapter_if.sv
// Bundle of the cache-side line ports and the burst memory port of cacheline_arbiter_adapter.
// slave = the adapter's view; master = the cache/memory environment's view.
interface cacheline_arbiter_adapter_if #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 32
);
    logic [NUM_CH*ADDR_W-1:0] dfp_addr;
    logic [NUM_CH-1:0]        dfp_read;
    logic [NUM_CH-1:0]        dfp_write;
    logic [NUM_CH*LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0]        dfp_rdata;
    logic [NUM_CH-1:0]        dfp_resp;

    logic [ADDR_W-1:0]        bmem_addr;
    logic                     bmem_read;
    logic                     bmem_write;
    logic [BUS_W-1:0]         bmem_wdata;
    logic                     bmem_ready;
    logic [ADDR_W-1:0]        bmem_raddr;
    logic [BUS_W-1:0]         bmem_rdata;
    logic                     bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter_adapter.sv
// Round-robin adapter serving NUM_CH cache line ports through one burst memory port (LINE_W/BUS_W beats).
// Optional macro CACHELINE_ARBITER_ADAPTER_RADDR_CHECK_EN: RD beats are accepted only when bmem_raddr matches.
module cacheline_arbiter_adapter #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    cacheline_arbiter_adapter_if.slave bus
);
    localparam int BEATS = LINE_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
    logic [LINE_W-1:0]   ch_wdata [NUM_CH];
    logic [NUM_CH-1:0]   ch_req;

    logic                win_found;
    logic [CH_W-1:0]     win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_read;
    int                  arb_cand;

    logic                beat_ok;

    logic [ADDR_W-1:0]   bmem_addr_o;
    logic                bmem_read_o;
    logic                bmem_write_o;
    logic [BUS_W-1:0]    bmem_wdata_o;
    logic [NUM_CH-1:0]   dfp_resp_o;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_addr[gi]  = bus.dfp_addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = bus.dfp_wdata[gi*LINE_W +: LINE_W];
            assign ch_req[gi]   = bus.dfp_read[gi] | bus.dfp_write[gi];
        end
    endgenerate

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_cand  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_cand = (int'(rr_q) + k) % NUM_CH;
            if (!win_found && ch_req[arb_cand]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(arb_cand);
            end
        end
    end

    assign win_addr = ch_addr[win_idx] & ALIGN_MASK;
    assign win_read = bus.dfp_read[win_idx];

`ifdef CACHELINE_ARBITER_ADAPTER_RADDR_CHECK_EN
    assign beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
`else
    logic unused_raddr;
    assign beat_ok      = bus.bmem_rvalid;
    assign unused_raddr = ^bus.bmem_raddr;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        line_d       = line_q;
        rdata_d      = rdata_q;
        bmem_addr_o  = '0;
        bmem_read_o  = 1'b0;
        bmem_write_o = 1'b0;
        bmem_wdata_o = '0;
        dfp_resp_o   = '0;

        case (state_q)
            S_IDLE: begin
                // Gated by rst so the command outputs read zero while reset is held.
                if (win_found && !rst) begin
                    bmem_addr_o = win_addr;
                    if (win_read) begin
                        bmem_read_o = 1'b1;
                    end else begin
                        bmem_write_o = 1'b1;
                        bmem_wdata_o = ch_wdata[win_idx][BUS_W-1:0];
                    end
                    if (bus.bmem_ready) begin
                        grant_d = win_idx;
                        addr_d  = win_addr;
                        rr_d    = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
                        if (win_read) begin
                            cnt_d   = '0;
                            state_d = S_RD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = S_WR;
                        end
                    end
                end
            end

            S_RD: begin
                bmem_addr_o = addr_q;
                if (beat_ok) begin
                    line_d[cnt_q*BUS_W +: BUS_W] = bus.bmem_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = line_d;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_WR: begin
                // Write beats come live from the requester, which holds its line until resp.
                bmem_addr_o  = addr_q;
                bmem_write_o = 1'b1;
                bmem_wdata_o = ch_wdata[grant_q][cnt_q*BUS_W +: BUS_W];
                if (bus.bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_RESP: begin
                dfp_resp_o[grant_q] = 1'b1;
                state_d             = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bmem_addr  = bmem_addr_o;
    assign bus.bmem_read  = bmem_read_o;
    assign bus.bmem_write = bmem_write_o;
    assign bus.bmem_wdata = bmem_wdata_o;
    assign bus.dfp_resp   = dfp_resp_o;
    assign bus.dfp_rdata  = rdata_q;
endmodule

// File: tb/tb_cacheline_arbiter_adapter.sv
// Scoreboard bench for cacheline_arbiter_adapter: random cache requests against a line-level memory model.
module tb_cacheline_arbiter_adapter;
    localparam int NUM_CH = 2;
    localparam int LINE_W = 256;
    localparam int BUS_W  = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BUS_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFE0;
    localparam logic [LINE_W-1:0] LINE1_C = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [LINE_W-1:0] WLINE_C = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    typedef struct {
        int                ch;
        bit                rd;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_arbiter_adapter_if #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) bus ();

    cacheline_arbiter_adapter #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    req_t              exp_q[$];
    int                resp_log[$];
    logic [LINE_W-1:0] ref_mem   [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] mem_store [logic [ADDR_W-1:0]];
    logic [NUM_CH-1:0] busy;
    int                ready_mode;  // 0: always ready, 1: random, 2: never ready

    logic [ADDR_W-1:0] last_rd_addr, last_wr_addr;
    logic [LINE_W-1:0] last_wr_line;
    int                last_rbeat_cyc = -100;
    int                last_wbeat_cyc = -100;
    int                rbeats_seen    = 0;

    function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        for (int b = 0; b < BEATS; b++) l[b*BUS_W +: BUS_W] = {a, 32'hC0DE_0000 ^ 32'(b)};
        return l;
    endfunction

    task automatic check_eq(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: accepts commands, returns read beats, collects write beats.
    initial begin : responder
        bit                rd_pending;
        int                rd_idx, wbeat;
        bit                beat_real, beat_last;
        logic [ADDR_W-1:0] rd_addr, wr_addr;
        logic [LINE_W-1:0] wr_line, src;
        rd_pending = 0; rd_idx = 0; wbeat = 0; beat_real = 0; beat_last = 0;
        rd_addr = '0; wr_addr = '0; wr_line = '0; src = '0;
        mem_store[32'h1220] = LINE1_C;
        bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0; bus.bmem_rdata = '0; bus.bmem_raddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_pending = 0; rd_idx = 0; wbeat = 0; beat_real = 0;
            end else begin
                if (bus.bmem_read && bus.bmem_ready) begin
                    rd_pending = 1; rd_idx = 0; rd_addr = bus.bmem_addr; last_rd_addr = bus.bmem_addr;
                end
                if (bus.bmem_write && bus.bmem_ready) begin
                    if (wbeat == 0) wr_addr = bus.bmem_addr;
                    wr_line[wbeat*BUS_W +: BUS_W] = bus.bmem_wdata;
                    wbeat++;
                    if (wbeat == BEATS) begin
                        mem_store[wr_addr] = wr_line;
                        last_wr_addr = wr_addr; last_wr_line = wr_line; last_wbeat_cyc = cyc; wbeat = 0;
                    end
                end
                if (bus.bmem_rvalid && beat_real) begin
                    rbeats_seen++;
                    if (beat_last) last_rbeat_cyc = cyc;
                end
            end
            @(posedge clk); #1;
            beat_real = 0; beat_last = 0;
            bus.bmem_rvalid = 1'b0;
            if (rst) begin
                bus.bmem_ready = 1'b0;
            end else begin
                case (ready_mode)
                    0:       bus.bmem_ready = 1'b1;
                    1:       bus.bmem_ready = ($urandom_range(0, 99) < 65);
                    default: bus.bmem_ready = 1'b0;
                endcase
                if (rd_pending) begin
                    if (ready_mode != 1 || $urandom_range(0, 99) < 70) begin
                        src = mem_store.exists(rd_addr) ? mem_store[rd_addr] : init_line(rd_addr);
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_rdata  = src[rd_idx*BUS_W +: BUS_W];
                        bus.bmem_raddr  = rd_addr;
                        beat_real = 1; beat_last = (rd_idx == BEATS - 1);
                        rd_idx++;
                        if (rd_idx == BEATS) rd_pending = 0;
                    end
`ifdef CACHELINE_ARBITER_ADAPTER_RADDR_CHECK_EN
                    else if ($urandom_range(0, 99) < 40) begin
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_raddr  = 32'hDEAD_0000;
                        bus.bmem_rdata  = {$urandom, $urandom};
                    end
`endif
                end else if (ready_mode == 1 && $urandom_range(0, 99) < 20) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr  = $urandom;
                    bus.bmem_rdata  = {$urandom, $urandom};
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each dfp_resp and checks against the line-level model.
    initial begin : monitor
        req_t              e;
        int                c, hit;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] exp_line;
        ref_mem[32'h1220] = LINE1_C;
        forever begin
            @(negedge clk);
            if (rst) begin
                check_eq("rst_outputs", {bus.dfp_resp, bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata}, '0);
                check_eq("rst_rdata", bus.dfp_rdata, '0);
            end else if (bus.dfp_resp != '0) begin
                check_eq("resp_onehot", $countones(bus.dfp_resp), 1);
                c = 0;
                for (int i = NUM_CH - 1; i >= 0; i--) if (bus.dfp_resp[i]) c = i;
                hit = -1;
                for (int i = 0; i < exp_q.size(); i++) if (hit < 0 && exp_q[i].ch == c) hit = i;
                checks++;
                if (hit < 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: channel %0d got resp, required no resp (nothing outstanding)", c);
                end else begin
                    e = exp_q[hit];
                    exp_q.delete(hit);
                    a = e.addr & ALIGN_MASK;
                    if (e.rd) begin
                        exp_line = ref_mem.exists(a) ? ref_mem[a] : init_line(a);
                        check_eq("rd_data", bus.dfp_rdata, exp_line);
                        check_eq("rd_cmd_addr", last_rd_addr, a);
                        check_eq("rd_latency", cyc, last_rbeat_cyc + 1);
                    end else begin
                        ref_mem[a] = e.wdata;
                        check_eq("wr_line", last_wr_line, e.wdata);
                        check_eq("wr_addr", last_wr_addr, a);
                        check_eq("wr_latency", cyc, last_wbeat_cyc + 1);
                    end
                    $display("resp ch%0d %s addr=%08h cycle=%0d", c, e.rd ? "RD" : "WR", a, cyc);
                end
                resp_log.push_back(c);
            end
        end
    end

    task automatic issue(input int c, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d);
        req_t e;
        bus.dfp_read[c]  = rd;
        bus.dfp_write[c] = wr;
        bus.dfp_addr[c*ADDR_W +: ADDR_W]  = a;
        bus.dfp_wdata[c*LINE_W +: LINE_W] = d;
        busy[c] = 1'b1;
        e.ch = c; e.rd = rd; e.addr = a; e.wdata = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic [NUM_CH-1:0] done;
        @(negedge clk);
        done = rst ? '0 : bus.dfp_resp;
        @(posedge clk); #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (done[c]) begin
                bus.dfp_read[c] = 1'b0; bus.dfp_write[c] = 1'b0; busy[c] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (busy != '0 && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (busy != '0) begin
            errors++;
            $display("FAIL wait_done: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return 32'h1000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
    endfunction

    initial begin : stimulus
        int base;
        bit rd, wr;
        int kind;
        logic [ADDR_W-1:0] a;
        bus.dfp_addr = '0; bus.dfp_read = '0; bus.dfp_write = '0; bus.dfp_wdata = '0;
        busy = '0; ready_mode = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single read, channel 0.
        issue(0, 1'b1, 1'b0, 32'h0000_1234, '0);
        wait_done(50);

        // Single write, channel 1, with random ready.
        ready_mode = 1;
        issue(1, 1'b0, 1'b1, 32'h0000_8040, WLINE_C);
        wait_done(100);

        // Simultaneous reads from reset: ch0 then ch1, twice (pointer wraps back to 0).
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ready_mode = 0;
        for (int r = 0; r < 2; r++) begin
            resp_log.delete();
            issue(0, 1'b1, 1'b0, rand_addr(), '0);
            issue(1, 1'b1, 1'b0, rand_addr(), '0);
            wait_done(100);
            check_eq("rr_count", resp_log.size(), 2);
            if (resp_log.size() == 2) begin
                check_eq("rr_first", resp_log[0], 0);
                check_eq("rr_second", resp_log[1], 1);
            end
        end

        // Memory stalls in IDLE: command held with its address.
        ready_mode = 2;
        a = rand_addr();
        issue(0, 1'b1, 1'b0, a, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_read", bus.bmem_read, 1'b1);
            check_eq("stall_addr", bus.bmem_addr, a & ALIGN_MASK);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        wait_done(50);

        // Reset after beat 1 of a read; the held request then completes.
        base = rbeats_seen;
        issue(0, 1'b1, 1'b0, rand_addr(), '0);
        for (int i = 0; i < 50 && rbeats_seen < base + 2; i++) begin
            @(negedge clk);
            if (rbeats_seen < base + 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_done(100);

        // Randomized traffic.
        ready_mode = 1;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!busy[c] && $urandom_range(0, 99) < 40) begin
                    kind = $urandom_range(0, 9);
                    rd = (kind < 5) || (kind == 9);
                    wr = (kind >= 5);
                    issue(c, rd, wr, rand_addr(),
                          {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
                end
            end
            step();
        end
        wait_done(500);
        repeat (3) step();
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
